// File: rtl/d_stage_pipe_pkg.sv
// mips_defs: shared decode constants for the MIPS decode stage.
//   - primary opcodes and SPECIAL funct codes used by the decoder
//   - REGIMM rt selectors for bltz/bgez
//   - immediate extender operation encoding
//   - forward-select value meaning "use the register file"
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] RT_BLTZ    = 5'd0;
    localparam logic [4:0] RT_BGEZ    = 5'd1;

    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic [1:0] {
        EXT_SEXT = 2'd0,
        EXT_ZEXT = 2'd1,
        EXT_LUI  = 2'd2
    } ext_op_e;

    // Forward select value that picks the register-file read.
    localparam int FWD_RF = 0;

endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREG x XLEN register file, two async read ports, one
// synchronous write port, with write-through bypass on both reads.
//   clk, reset    : clock, synchronous active-high reset (clears all entries)
//   we, wa, wd    : write enable / address / data (W stage)
//   wpc           : W-stage PC, only printed in the write trace
//   ra1, ra2      : read addresses
//   rd1, rd2      : read data; register 0 always reads 0
module regfile_bypass #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [XLEN-1:0] wpc,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
            $display("%0t rf write: pc=%h r%0d=%h", $time, wpc, wa, wd);
        end
    end

    // A write landing this cycle is visible to the reader in the same cycle,
    // so decode never sees the stale value while W is writing back.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = (wr_en && wa == ra1) ? wd : regs[ra1];
        if (ra2 != '0) rd2 = (wr_en && wa == ra2) ? wd : regs[ra2];
    end

endmodule

// File: rtl/d_stage_pipe.sv
// d_stage_pipe: decode stage of the five-stage MIPS pipeline.
// Holds the IF/ID register, reads the register file (with write-through),
// applies the forwarding network, extends the immediate, evaluates branch
// conditions and produces the fetch redirect.
//   if_instr, if_pc4        : instruction and PC+4 from fetch
//   stall, flush            : hold / squash the IF/ID register (stall wins)
//   we, wa, wd, wpc         : register-file write port from W stage
//   fwd_data, fwd_rs/fwd_rt : forwarded values and per-operand selects
//   d_instr, d_pc4, d_valid : IF/ID register contents
//   rd1, rd2                : forwarded rs/rt operands
//   imm32                   : extended immediate
//   nextpc, pc_sel          : redirect target and redirect request
//   waout                   : destination register of the decoded instruction
module d_stage_pipe
    import mips_defs::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NFWD = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000,
    localparam int AW = $clog2(NREG),
    localparam int FW = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          if_instr,
    input  logic [XLEN-1:0]      if_pc4,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [XLEN-1:0]      wd,
    input  logic [XLEN-1:0]      wpc,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [FW-1:0]        fwd_rs,
    input  logic [FW-1:0]        fwd_rt,
    output logic [31:0]          d_instr,
    output logic [XLEN-1:0]      d_pc4,
    output logic                 d_valid,
    output logic [XLEN-1:0]      rd1,
    output logic [XLEN-1:0]      rd2,
    output logic [XLEN-1:0]      imm32,
    output logic [XLEN-1:0]      nextpc,
    output logic                 pc_sel,
    output logic [AW-1:0]        waout
);

    // IF/ID register: reset > stall > flush > load
    always_ff @(posedge clk) begin
        if (reset) begin
            d_instr <= '0;
            d_pc4   <= RESET_PC + XLEN'(4);
            d_valid <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                d_instr <= '0;
                d_pc4   <= if_pc4;
                d_valid <= 1'b0;
            end else begin
                d_instr <= if_instr;
                d_pc4   <= if_pc4;
                d_valid <= 1'b1;
            end
        end
    end

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    assign op    = d_instr[31:26];
    assign rs    = d_instr[25:21];
    assign rt    = d_instr[20:16];
    assign rd    = d_instr[15:11];
    assign fn    = d_instr[5:0];
    assign imm16 = d_instr[15:0];

    logic [XLEN-1:0] rf_rd1, rf_rd2;

    regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .wpc   (wpc),
        .ra1   (AW'(rs)),
        .ra2   (AW'(rt)),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2)
    );

    // Select FWD_RF, or any value beyond the last source, keeps the RF read.
    always_comb begin
        rd1 = rf_rd1;
        rd2 = rf_rd2;
        for (int k = FWD_RF + 1; k <= NFWD; k++) begin
            if (fwd_rs == FW'(k)) rd1 = fwd_data[(k-1)*XLEN +: XLEN];
            if (fwd_rt == FW'(k)) rd2 = fwd_data[(k-1)*XLEN +: XLEN];
        end
    end

    logic [XLEN-1:0] sext_imm, br_target, j_target;

    assign sext_imm  = {{(XLEN-16){imm16[15]}}, imm16};
    assign br_target = d_pc4 + (sext_imm << 2);
    assign j_target  = {d_pc4[XLEN-1:28], d_instr[25:0], 2'b00};

    ext_op_e ext_op;
    logic    taken, jump, jreg;
    logic    rd1_neg, rd1_zero;

    assign rd1_neg  = rd1[XLEN-1];
    assign rd1_zero = (rd1 == '0);

    always_comb begin
        ext_op = EXT_SEXT;
        taken  = 1'b0;
        jump   = 1'b0;
        jreg   = 1'b0;
        waout  = '0;
        case (op)
            OP_SPECIAL: begin
                waout = AW'(rd);
                if (fn == FN_JR) begin
                    jreg  = 1'b1;
                    waout = '0;
                end else if (fn == FN_JALR) begin
                    jreg  = 1'b1;
                end
            end
            OP_REGIMM: begin
                // Remaining rt encodings decode as nop.
                if (rt == RT_BLTZ)      taken = rd1_neg;
                else if (rt == RT_BGEZ) taken = !rd1_neg;
            end
            OP_BEQ:  taken = (rd1 == rd2);
            OP_BNE:  taken = (rd1 != rd2);
            OP_BLEZ: taken = rd1_neg || rd1_zero;
            OP_BGTZ: taken = !rd1_neg && !rd1_zero;
            OP_J:    jump  = 1'b1;
            OP_JAL: begin
                jump  = 1'b1;
                waout = AW'(REG_RA);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ext_op = EXT_ZEXT;
                waout  = AW'(rt);
            end
            OP_LUI: begin
                ext_op = EXT_LUI;
                waout  = AW'(rt);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: waout = AW'(rt);
            OP_SB, OP_SH, OP_SW: ;  // stores write no register
            default: ;              // unknown opcodes behave as nop
        endcase
    end

    always_comb begin
        case (ext_op)
            EXT_ZEXT: imm32 = {{(XLEN-16){1'b0}}, imm16};
            EXT_LUI:  imm32 = sext_imm << 16;
            default:  imm32 = sext_imm;
        endcase
    end

    assign nextpc = jreg ? rd1 : (jump ? j_target : br_target);
    assign pc_sel = d_valid && (taken || jump || jreg);

endmodule

// File: tb/tb_d_stage_pipe.sv
module tb_d_stage_pipe;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NFWD = 2;
    localparam int AW   = 5;
    localparam int FW   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [31:0]          if_instr;
    logic [XLEN-1:0]      if_pc4;
    logic                 stall, flush, we;
    logic [AW-1:0]        wa;
    logic [XLEN-1:0]      wd, wpc;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [FW-1:0]        fwd_rs, fwd_rt;
    logic [31:0]          d_instr;
    logic [XLEN-1:0]      d_pc4, rd1, rd2, imm32, nextpc;
    logic                 d_valid, pc_sel;
    logic [AW-1:0]        waout;

    d_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc4(if_pc4),
        .stall(stall), .flush(flush), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .fwd_data(fwd_data), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .d_instr(d_instr), .d_pc4(d_pc4), .d_valid(d_valid),
        .rd1(rd1), .rd2(rd2), .imm32(imm32), .nextpc(nextpc),
        .pc_sel(pc_sel), .waout(waout)
    );

    // reference model state
    logic [31:0] m_regs [NREG];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid;
    logic [31:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] fwd_pick(input logic [FW-1:0] sel, input logic [31:0] rfv);
        int s = int'(sel);
        if (s >= 1 && s <= NFWD) return fwd_data[(s-1)*XLEN +: XLEN];
        return rfv;
    endfunction

    // Clock edge: advance the model with the inputs the DUT just sampled.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_instr = 32'h0;
            m_pc4   = RESET_PC + 32'd4;
            m_valid = 1'b0;
            for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
        end else begin
            if (!stall) begin
                m_instr = flush ? 32'h0 : if_instr;
                m_valid = !flush;
                m_pc4   = if_pc4;
            end
            if (we && wa != 5'd0) m_regs[wa] = wd;
        end
        exp_q.push_back(m_instr);
        #1;
    endtask

    // Mid-cycle: compare every output with the model's decode of the rules.
    task automatic settle();
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, e_wa;
        logic [15:0] imm;
        logic [31:0] a, b, sx, e_imm, e_next, e_instr;
        logic        e_redir;
        @(negedge clk);
        op = m_instr[31:26]; rs = m_instr[25:21]; rt = m_instr[20:16];
        rd = m_instr[15:11]; fn = m_instr[5:0];   imm = m_instr[15:0];
        a  = fwd_pick(fwd_rs, rf_read(rs));
        b  = fwd_pick(fwd_rt, rf_read(rt));
        sx = {{16{imm[15]}}, imm};
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e_imm = {16'h0, imm};
        else if (op == 6'h0F)                           e_imm = {imm, 16'h0};
        else                                            e_imm = sx;
        e_redir = 1'b0;
        e_wa    = 5'd0;
        e_next  = m_pc4 + sx * 4;
        case (op)
            6'h00: begin
                e_wa = rd;
                if (fn == 6'h08) begin e_redir = 1'b1; e_wa = 5'd0; e_next = a; end
                else if (fn == 6'h09) begin e_redir = 1'b1; e_next = a; end
            end
            6'h01: begin
                if (rt == 5'd0)      e_redir = ($signed(a) < 0);
                else if (rt == 5'd1) e_redir = ($signed(a) >= 0);
            end
            6'h02: begin e_redir = 1'b1; e_next = {m_pc4[31:28], m_instr[25:0], 2'b00}; end
            6'h03: begin e_redir = 1'b1; e_next = {m_pc4[31:28], m_instr[25:0], 2'b00}; e_wa = 5'd31; end
            6'h04: e_redir = (a == b);
            6'h05: e_redir = (a != b);
            6'h06: e_redir = ($signed(a) <= 0);
            6'h07: e_redir = ($signed(a) > 0);
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: e_wa = rt;
            default: ;
        endcase
        e_instr = (exp_q.size() > 0) ? exp_q.pop_front() : m_instr;
        chk("d_instr", d_instr, e_instr);
        chk("d_pc4",   d_pc4,   m_pc4);
        chk("d_valid", {31'h0, d_valid}, {31'h0, m_valid});
        chk("rd1",     rd1,     a);
        chk("rd2",     rd2,     b);
        chk("imm32",   imm32,   e_imm);
        chk("waout",   {27'h0, waout}, {27'h0, e_wa});
        chk("pc_sel",  {31'h0, pc_sel}, {31'h0, m_valid & e_redir});
        if (e_redir) chk("nextpc", nextpc, e_next);
    endtask

    task automatic set_defaults();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        we = 1'b0; wa = '0; wd = '0; wpc = '0;
        fwd_rs = '0; fwd_rt = '0; fwd_data = '0;
    endtask

    // driver: one cycle that presents an instruction to fetch
    task automatic load(input logic [31:0] instr, input logic [31:0] pc4);
        set_defaults();
        if_instr = instr;
        if_pc4   = pc4;
        settle();
        tick();
    endtask

    // driver: register write while the decode slot is held
    task automatic rf_write(input logic [4:0] a, input logic [31:0] v);
        set_defaults();
        stall = 1'b1; we = 1'b1; wa = a; wd = v; wpc = 32'h0000_4000 + {27'h0, a};
        settle();
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [21];
        logic [5:0] fns [5];
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
                6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h2B, 6'h1C, 6'h3F};
        fns = '{6'h08, 6'h09, 6'h20, 6'h21, 6'h2A};
        op = ops[$urandom_range(0, 20)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 31));
        case (op)
            6'h00:        return {op, rs, rt, rd, 5'h0, fns[$urandom_range(0, 4)]};
            6'h01:        return {op, rs, 5'($urandom_range(0, 2)), 16'($urandom)};
            6'h02, 6'h03: return {op, 26'($urandom)};
            default:      return {op, rs, rt, 16'($urandom)};
        endcase
    endfunction

    logic [31:0] lui_i, ori_i;

    initial begin
        set_defaults();
        if_instr = '0;
        if_pc4   = '0;
        m_instr  = '0; m_pc4 = '0; m_valid = 1'b0;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;

        // reset, then an idle (held) cycle
        reset = 1'b1;
        tick();
        tick();
        exp_q.delete();
        exp_q.push_back(32'h0);
        set_defaults();
        stall = 1'b1;
        settle();
        chk("rst_d_valid", {31'h0, d_valid}, 32'h0);
        chk("rst_d_pc4",   d_pc4,            32'h0000_3004);
        chk("rst_pc_sel",  {31'h0, pc_sel},  32'h0);
        tick();

        // cleared RF, then same-cycle bypass of $5
        load({6'h00, 5'd5, 5'd9, 5'd4, 5'd0, 6'h21}, 32'h0000_3008);
        set_defaults();
        stall = 1'b1;
        settle();
        chk("rf_clear_rs", rd1, 32'h0);
        chk("rf_clear_rt", rd2, 32'h0);
        tick();
        stall = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'h0000_1234; wpc = 32'h0000_3000;
        settle();
        chk("bypass_rd1", rd1, 32'h0000_1234);
        tick();

        // write to $0 is ignored
        set_defaults();
        if_instr = {6'h00, 5'd0, 5'd5, 5'd4, 5'd0, 6'h21};
        if_pc4   = 32'h0000_300C;
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        settle();
        tick();
        set_defaults();
        stall = 1'b1;
        settle();
        chk("r0_zero",  rd1, 32'h0);
        chk("r5_value", rd2, 32'h0000_1234);
        tick();

        // beq $1,$2,-1
        rf_write(5'd1, 32'd6);
        rf_write(5'd2, 32'd7);
        load({6'h04, 5'd1, 5'd2, 16'hFFFF}, 32'h0000_3010);
        set_defaults();
        stall = 1'b1; fwd_rs = 2'd1; fwd_data = {32'h0, 32'd7};
        settle();
        chk("beq_fwd_pc_sel", {31'h0, pc_sel}, 32'h1);
        chk("beq_fwd_nextpc", nextpc, 32'h0000_300C);
        tick();
        fwd_rs = 2'd0;
        settle();
        chk("beq_rf_pc_sel", {31'h0, pc_sel}, 32'h0);
        tick();

        // signed zero tests
        rf_write(5'd3, 32'h8000_0000);
        load({6'h01, 5'd3, 5'd0, 16'h0004}, 32'h0000_3014);
        stall = 1'b1;
        settle();
        chk("bltz_pc_sel", {31'h0, pc_sel}, 32'h1);
        tick();
        load({6'h01, 5'd3, 5'd1, 16'h0004}, 32'h0000_3018);
        stall = 1'b1;
        settle();
        chk("bgez_pc_sel", {31'h0, pc_sel}, 32'h0);
        tick();
        load({6'h06, 5'd0, 5'd0, 16'h0004}, 32'h0000_301C);
        stall = 1'b1;
        settle();
        chk("blez_pc_sel", {31'h0, pc_sel}, 32'h1);
        tick();

        // jal, then flush on the following edge
        load({6'h03, 26'h0000C01}, 32'h0000_3020);
        set_defaults();
        flush = 1'b1;
        settle();
        chk("jal_nextpc", nextpc, 32'h0000_3004);
        chk("jal_waout",  {27'h0, waout}, 32'd31);
        tick();
        set_defaults();
        stall = 1'b1;
        settle();
        chk("flush_d_valid", {31'h0, d_valid}, 32'h0);
        chk("flush_pc_sel",  {31'h0, pc_sel},  32'h0);
        chk("flush_d_instr", d_instr,          32'h0);
        tick();

        // lui, held by stall+flush while fetch keeps changing
        lui_i = {6'h0F, 5'd0, 5'd1, 16'hABCD};
        ori_i = {6'h0D, 5'd0, 5'd2, 16'h8000};
        load(lui_i, 32'h0000_3040);
        for (int i = 0; i < 3; i++) begin
            set_defaults();
            stall = 1'b1; flush = 1'b1;
            if_instr = $urandom; if_pc4 = $urandom & 32'hFFFF_FFFC;
            settle();
            chk("hold_d_instr", d_instr, lui_i);
            chk("hold_d_pc4",   d_pc4,   32'h0000_3040);
            if (i == 0) chk("lui_imm32", imm32, 32'hABCD_0000);
            tick();
        end
        load(ori_i, 32'h0000_3050);
        set_defaults();
        stall = 1'b1;
        settle();
        chk("release_d_valid", {31'h0, d_valid}, 32'h1);
        chk("release_d_instr", d_instr,          ori_i);
        chk("ori_imm32",       imm32,            32'h0000_8000);
        tick();

        // reset during a stall clears the stage
        set_defaults();
        stall = 1'b1; reset = 1'b1;
        settle();
        tick();
        set_defaults();
        stall = 1'b1;
        settle();
        chk("stall_rst_d_valid", {31'h0, d_valid}, 32'h0);
        chk("stall_rst_d_pc4",   d_pc4,            32'h0000_3004);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            set_defaults();
            reset    = ($urandom_range(0, 63) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            if_instr = rand_instr();
            if_pc4   = $urandom & 32'hFFFF_FFFC;
            we       = $urandom_range(0, 1);
            wa       = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       wd = 32'h0;
                1:       wd = 32'($urandom_range(0, 3));
                default: wd = $urandom;
            endcase
            wpc      = $urandom;
            fwd_rs   = 2'($urandom_range(0, 3));
            fwd_rt   = 2'($urandom_range(0, 3));
            fwd_data = {32'($urandom_range(0, 3)), ($urandom_range(0, 1) ? $urandom : 32'h0)};
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
